// File: rtl/mux_16to1_pkg.sv
// Shared constants for the serial frame mux: frame width and bit-pointer width.
package mux_16to1_pkg;

  localparam int FRAME_W = 16;
  localparam int SEL_W   = 4;

endpackage

// File: rtl/mux_2to1.sv
// Single-bit 2:1 select cell; one leaf of the 16:1 bit-select tree.
module mux_2to1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // The inner test keeps an unknown select from merging equal inputs into a
  // known value; a known select still passes a z operand straight through.
  assign y = s ? b : ((s == 1'b0) ? a : 1'bx);

endmodule

// File: rtl/mux_16to1.sv
// Presents data_in[sel] on data_out, either directly or through one SCLK flop.
module mux_16to1
  import mux_16to1_pkg::*;
#(
  parameter bit REGISTERED = 1'b0
) (
  input  logic               SCLK,
  input  logic               nRST,
  input  logic [FRAME_W-1:0] data_in,
  output logic               data_out,
  input  logic [SEL_W-1:0]   sel
);

  logic [7:0] lvl0_p0;
  logic [3:0] lvl1_p0;
  logic [1:0] lvl2_p0;
  logic       mux_p0;

  // Stage p0: four-level select tree, level k steered by sel[k]
  for (genvar i = 0; i < 8; i++) begin : g_lvl0
    mux_2to1 u_mux (
      .a (data_in[2*i]),
      .b (data_in[2*i+1]),
      .s (sel[0]),
      .y (lvl0_p0[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    mux_2to1 u_mux (
      .a (lvl0_p0[2*i]),
      .b (lvl0_p0[2*i+1]),
      .s (sel[1]),
      .y (lvl1_p0[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    mux_2to1 u_mux (
      .a (lvl1_p0[2*i]),
      .b (lvl1_p0[2*i+1]),
      .s (sel[2]),
      .y (lvl2_p0[i])
    );
  end

  mux_2to1 u_lvl3 (
    .a (lvl2_p0[0]),
    .b (lvl2_p0[1]),
    .s (sel[3]),
    .y (mux_p0)
  );

  // Stage p1: optional output flop on rising SCLK
  if (REGISTERED) begin : g_reg
    logic data_p1;

    always_ff @(posedge SCLK) begin
      if (!nRST) begin
        data_p1 <= 1'b0;
      end else begin
        data_p1 <= mux_p0;
      end
    end

    assign data_out = data_p1;
  end else begin : g_comb
    // Clock and reset have no function when the output is combinational.
    logic unused_ctrl;
    assign unused_ctrl = SCLK ^ nRST;
    assign data_out    = mux_p0;
  end

endmodule

// File: tb/tb_mux_16to1.sv
// Bench for mux_16to1: one combinational and one registered instance, checked
// against a queue of expected bits pushed as each stimulus step is driven.
module tb_mux_16to1;

  typedef struct {
    string tag;
    logic  exp;
  } sb_t;

  logic        SCLK;
  logic        nRST;
  logic [15:0] data_c;
  logic [3:0]  sel_c;
  logic        out_c;
  logic [15:0] data_r;
  logic [3:0]  sel_r;
  logic        out_r;

  sb_t sb[$];
  int  errors;
  int  checks;

  mux_16to1 #(.REGISTERED(1'b0)) u_comb (
    .SCLK     (SCLK),
    .nRST     (nRST),
    .data_in  (data_c),
    .data_out (out_c),
    .sel      (sel_c)
  );

  mux_16to1 #(.REGISTERED(1'b1)) u_reg (
    .SCLK     (SCLK),
    .nRST     (nRST),
    .data_in  (data_r),
    .data_out (out_r),
    .sel      (sel_r)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic exp);
    sb_t item;
    item.tag = tag;
    item.exp = exp;
    sb.push_back(item);
  endtask

  task automatic check(input logic obs);
    sb_t item;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%b expected=<queued entry>", obs);
    end else begin
      item = sb.pop_front();
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s: observed=%b expected=%b", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic sample_after_rise();
    @(posedge SCLK);
    #1;
  endtask

  initial begin
    logic [15:0] sweep_exp;
    logic [15:0] tri_word;
    logic [15:0] frame_word;
    logic [15:1] frame_exp;

    errors     = 0;
    checks     = 0;
    nRST       = 1'b0;
    data_c     = 16'h0000;
    sel_c      = 4'd0;
    data_r     = 16'h0000;
    sel_r      = 4'd0;
    sweep_exp  = 16'b1010_0101_1100_0011;
    tri_word   = {1'b0, 12'hABC, 2'b00, 1'bz};
    frame_word = {1'b0, 12'h001, 3'b00z};
    frame_exp  = 15'b0_000000000001_00;

    // Combinational sweep, sel stepped from 15 down to 0
    data_c = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      sel_c = 4'(i);
      push($sformatf("sweep_sel%0d", i), sweep_exp[i]);
      #1;
      check(out_c);
    end

    // Tristated slot; a 4-state read of the word gives z for slot 0
    data_c = tri_word;
    sel_c  = 4'd0;
    push("tri_sel0", tri_word[0]);
    #1;
    check(out_c);
    sel_c = 4'd15;
    push("tri_sel15", 1'b0);
    #1;
    check(out_c);
    sel_c = 4'd14;
    push("tri_sel14", 1'b1);
    #1;
    check(out_c);

    // Unknown select: indexing with an x index yields x in the expectation
    data_c = 16'hFFFF;
    sel_c  = 4'bx010;
    push("unknown_sel", data_c[sel_c]);
    #1;
    check(out_c);
    sel_c = 4'b1010;
    push("known_sel10", 1'b1);
    #1;
    check(out_c);

    // Registered: reset, release, hold between edges, next edge
    @(negedge SCLK);
    nRST   = 1'b0;
    data_r = 16'hFFFF;
    sel_r  = 4'd3;
    push("reg_reset", 1'b0);
    sample_after_rise();
    check(out_r);

    @(negedge SCLK);
    nRST = 1'b1;
    push("reg_release", 1'b1);
    sample_after_rise();
    check(out_r);

    @(negedge SCLK);
    data_r = 16'hA5C3;
    sel_r  = 4'd0;
    push("reg_sel0", 1'b1);
    sample_after_rise();
    check(out_r);
    #1;
    sel_r = 4'd2;
    push("reg_hold", 1'b1);
    #1;
    check(out_r);
    @(negedge SCLK);
    push("reg_sel2", 1'b0);
    sample_after_rise();
    check(out_r);

    // Mid-stream reset while streaming ones
    @(negedge SCLK);
    data_r = 16'hFFFF;
    sel_r  = 4'd7;
    push("stream_a", 1'b1);
    sample_after_rise();
    check(out_r);
    @(negedge SCLK);
    sel_r = 4'd12;
    push("stream_b", 1'b1);
    sample_after_rise();
    check(out_r);
    @(negedge SCLK);
    nRST  = 1'b0;
    sel_r = 4'd5;
    push("stream_reset", 1'b0);
    sample_after_rise();
    check(out_r);
    @(negedge SCLK);
    nRST = 1'b1;
    push("stream_resume", 1'b1);
    sample_after_rise();
    check(out_r);

    // SPI frame: bit pointer counts down on falling SCLK, sampled in high phase
    @(negedge SCLK);
    data_c = frame_word;
    sel_c  = 4'd15;
    for (int i = 15; i >= 0; i--) begin
      if (i > 0) begin
        push($sformatf("frame_slot%0d", i), frame_exp[i]);
      end else begin
        push("frame_slot0", frame_word[0]);
      end
      sample_after_rise();
      check(out_c);
      @(negedge SCLK);
      sel_c = sel_c - 4'd1;
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_16to1.md
# mux_16to1

Bit-select multiplexer that drives one bit of a 16-bit word onto a single output, chosen by a 4-bit index. In the ADC-emulating SPI slave it serialises the frame word onto DOUT: the bit pointer steps down on each falling SCLK edge, and this block presents the indexed bit. The default mode is purely combinational. An optional registered mode adds one output flop on the serial clock with a synchronous active-low reset.

## Interface
- `REGISTERED`, default 0: 0 = combinational output; 1 = output registered on rising `SCLK`.
- `SCLK` input 1: serial clock; used only when `REGISTERED=1`.
- `nRST` input 1: reset, synchronous and active-low; used only when `REGISTERED=1`.
- `data_in` input 16: word to serialise; bit 15 = first (MSB) slot, bit 0 = last slot.
- `sel` input 4: index of the bit to present, 0–15.
- `data_out` output 1: the selected bit.
- One clock, `SCLK`. Reset `nRST` is synchronous and active-low.
- Connect ports by name. The port order is SCLK, nRST, data_in, data_out, sel.

## Operation
- `REGISTERED=0`:
  - `data_out = data_in[sel]` continuously.
  - No state; `SCLK` and `nRST` are ignored.
- High-impedance pass-through (combinational mode):
  - If the selected bit is `1'bz`, `data_out` is `1'bz`. The SPI frame word holds `z` in bit 0 for the tristated 16th slot.
  - Build the selection with conditional/ternary 2:1 stages so `z` propagates.
  - Do not use a `case` statement with a constant default.
- Unknown select: if any `sel` bit is x/z, `data_out` is x. It must never silently resolve to 0.
- `REGISTERED=1`:
  - On rising `SCLK` with `nRST=0`: `data_out` becomes 0.
  - On rising `SCLK` with `nRST=1`: `data_out` becomes `data_in[sel]`, sampled just before the edge.
  - Tristate is not preserved in this mode; a `z` input bit registers as an unspecified value, not checked.
- Wrap-around: none inside the block. `sel` is a plain index, and all 16 values are legal.
- Width rules: `data_in` is exactly 16 bits and `sel` exactly 4 bits. No parameterised width.

## Timing
- `REGISTERED=0`:
  - Latency 0; `data_out` follows any change on `data_in` or `sel` within the same delta/timestep.
  - With `sel` updated on falling `SCLK`, the new bit is valid for the whole following high phase.
- `REGISTERED=1`:
  - Latency 1 rising edge of `SCLK`.
  - Reset value of `data_out` is 0, applied on the first rising edge with `nRST` low.
  - Reset asserted mid-frame clears the output on the next rising edge, regardless of `sel`.
  - Releasing `nRST` resumes normal sampling on the next rising edge.
- Before the first clock edge in registered mode, `data_out` is undefined.
- Simultaneous change of `data_in` and `sel`: the output reflects both new values. The combinational result settles to the final selection; the registered result is taken at the edge.

## Structure
- No shared package needed; no typedefs.
- The one natural constant is the frame width 16. If the SPI package exists, it belongs there beside the ADC frame constants.
- Sub-module `mux_2to1`: inputs a, b, s, output y, with `y = s ? b : a`.
  - Instantiated as a 4-level tree: 8 + 4 + 2 + 1 = 15 instances.
  - Level k is selected by `sel[k]`, so `z` and x propagate naturally.
- The output flop lives in a generate branch, present only for `REGISTERED=1`.

## Test plan
- Combinational sweep: `data_in=16'hA5C3`; step `sel` 15 down to 0 -> `data_out` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
- Tristate slot: `data_in={1'b0,12'hABC,2'b00,1'bz}`; `sel=0` -> `data_out=z`.
  - Same word, `sel=15` -> 0.
  - `sel=14` -> 1, the MSB of 12'hABC.
- Unknown select: `data_in=16'hFFFF`, `sel=4'bx010` -> `data_out=x`.
  - `sel=4'b1010` -> 1.
- Registered mode, `REGISTERED=1`: `nRST=0` for one rising edge with `data_in=16'hFFFF` -> `data_out=0`.
  - Release reset with `sel=3` -> 1 after exactly one rising edge.
  - No change between edges when `sel` toggles.
- Mid-stream reset: registered mode, `data_in=16'hFFFF` streaming 1s; assert `nRST` low for one edge -> 0 that edge, 1 the next.
- SPI frame integration: drive `sel` from a down-counter updated on falling `SCLK`, starting at 15, with `data_in={1'b0,12'h001,3'b00z}` -> serial stream 0, 000000000001, 0, 0, z.
